// File: rtl/thumb_pkg.sv
// rtl/thumb_pkg.sv - Thumb class codes, format prefixes and halfword encode function
package thumb_pkg;

    // Instruction class codes shared with the decode control unit
    localparam logic [4:0] CLS_INVALID  = 5'd0;
    localparam logic [4:0] CLS_SHIFT    = 5'd1;
    localparam logic [4:0] CLS_ADD_SUB  = 5'd2;
    localparam logic [4:0] CLS_MOVE_C   = 5'd3;
    localparam logic [4:0] CLS_ALU      = 5'd4;
    localparam logic [4:0] CLS_HIREG    = 5'd6;
    localparam logic [4:0] CLS_LDSR_REG = 5'd7;
    localparam logic [4:0] CLS_LDSR_IMM = 5'd9;
    localparam logic [4:0] CLS_LDSR_SP  = 5'd11;
    localparam logic [4:0] CLS_LD_A     = 5'd12;
    localparam logic [4:0] CLS_COND_B   = 5'd16;
    localparam logic [4:0] CLS_UNCOND_B = 5'd18;
    localparam logic [4:0] CLS_LONG_BL  = 5'd20;

    // Fixed opcode prefixes of each halfword format
    localparam logic [2:0] PFX_SHIFT    = 3'b000;
    localparam logic [4:0] PFX_ADD_SUB  = 5'b00011;
    localparam logic [2:0] PFX_MOVE_C   = 3'b001;
    localparam logic [5:0] PFX_ALU      = 6'b010000;
    localparam logic [5:0] PFX_HIREG    = 6'b010001;
    localparam logic [3:0] PFX_LDSR_REG = 4'b0101;
    localparam logic [2:0] PFX_LDSR_IMM = 3'b011;
    localparam logic [3:0] PFX_LDSR_SP  = 4'b1001;
    localparam logic [3:0] PFX_LD_A     = 4'b1010;
    localparam logic [3:0] PFX_COND_B   = 4'b1101;
    localparam logic [4:0] PFX_UNCOND_B = 5'b11100;
    localparam logic [4:0] PFX_BL_HI    = 5'b11110;
    localparam logic [4:0] PFX_BL_LO    = 5'b11111;

    typedef enum logic {ST_IDLE, ST_BL2} enc_state_e;

    typedef struct packed {
        logic        ok;
        logic [15:0] hw;
    } enc_result_t;

    // Single-halfword encoding (first halfword for LONG_BL) plus legality verdict
    function automatic enc_result_t encode(
        input logic [4:0]  cls,
        input logic [3:0]  op,
        input logic [3:0]  rd,
        input logic [3:0]  rs,
        input logic [3:0]  rn,
        input logic [21:0] imm
    );
        enc_result_t res;
        res.ok = 1'b1;
        res.hw = 16'h0000;
        case (cls)
            CLS_SHIFT: begin
                res.hw = {PFX_SHIFT, op[1:0], imm[4:0], rs[2:0], rd[2:0]};
                if (op[1:0] == 2'b11) res.ok = 1'b0;
            end
            CLS_ADD_SUB:  res.hw = {PFX_ADD_SUB, op[1:0], rn[2:0], rs[2:0], rd[2:0]};
            CLS_MOVE_C:   res.hw = {PFX_MOVE_C, op[1:0], rd[2:0], imm[7:0]};
            CLS_ALU:      res.hw = {PFX_ALU, op, rs[2:0], rd[2:0]};
            CLS_HIREG:    res.hw = {PFX_HIREG, op[1:0], rd[3], rs[3], rs[2:0], rd[2:0]};
            CLS_LDSR_REG: res.hw = {PFX_LDSR_REG, op[1:0], 1'b0, rn[2:0], rs[2:0], rd[2:0]};
            CLS_LDSR_IMM: res.hw = {PFX_LDSR_IMM, op[1:0], imm[4:0], rs[2:0], rd[2:0]};
            CLS_LDSR_SP:  res.hw = {PFX_LDSR_SP, op[0], rd[2:0], imm[7:0]};
            CLS_LD_A:     res.hw = {PFX_LD_A, op[0], rd[2:0], imm[7:0]};
            CLS_COND_B: begin
                res.hw = {PFX_COND_B, op, imm[7:0]};
                if (op[3:1] == 3'b111) res.ok = 1'b0;
            end
            CLS_UNCOND_B: res.hw = {PFX_UNCOND_B, imm[10:0]};
            CLS_LONG_BL:  res.hw = {PFX_BL_HI, imm[21:11]};
            default:      res.ok = 1'b0;
        endcase
        // Only the hi-register format can address r8-r15
        if (cls != CLS_HIREG && (rd[3] || rs[3] || rn[3])) res.ok = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - 16-bit synchronous FIFO for encoded halfwords
module enc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [15:0] i_data,
    input  logic        i_pop,
    output logic [15:0] o_data,
    output logic        o_full,
    output logic        o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Full is judged before this cycle's pop, so a pop never makes room for a same-cycle push
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage array write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/thumb_encoder.sv
// rtl/thumb_encoder.sv - Thumb instruction encoder with halfword output queue (option: THUMB_ENC_STATS_EN)
module thumb_encoder
    import thumb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_cls,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rs,
    input  logic [3:0]  in_rn,
    input  logic [21:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic        err,
    output logic [15:0] stat_instr,
    output logic [7:0]  stat_err
);
    enc_state_e  r_state;
    enc_state_e  w_state_nxt;
    logic [10:0] r_bl_lo;
    logic        r_err;
    enc_result_t w_enc;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic [15:0] w_push_data;
    logic        w_pop;

    assign w_enc     = encode(in_cls, in_op, in_rd, in_rs, in_rn, in_imm);
    assign in_ready  = (r_state == ST_IDLE) && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign err       = r_err;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (out_instr),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next state and FIFO push source: encoded request in IDLE, stored BL low half in BL2
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = w_enc.hw;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_enc.ok) begin
                    w_push = 1'b1;
                    if (in_cls == CLS_LONG_BL) w_state_nxt = ST_BL2;
                end
            end
            ST_BL2: begin
                w_push_data = {PFX_BL_LO, r_bl_lo};
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and error pulse for the cycle after a rejected accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && !w_enc.ok;
        end
    end

    // Low offset bits held for the second BL halfword
    always_ff @(posedge clk) begin
        if (w_accept) r_bl_lo <= in_imm[10:0];
    end

`ifdef THUMB_ENC_STATS_EN
    logic [15:0] r_stat_instr;
    logic [7:0]  r_stat_err;

    // Accepted-instruction counter wraps; reject counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_instr <= '0;
            r_stat_err   <= '0;
        end else if (w_accept) begin
            if (w_enc.ok)                r_stat_instr <= r_stat_instr + 16'd1;
            else if (r_stat_err != 8'hFF) r_stat_err  <= r_stat_err + 8'd1;
        end
    end

    assign stat_instr = r_stat_instr;
    assign stat_err   = r_stat_err;
`else
    assign stat_instr = '0;
    assign stat_err   = '0;
`endif
endmodule

// File: tb/tb_thumb_encoder.sv
// tb/tb_thumb_encoder.sv - directed table-driven bench for thumb_encoder
module tb_thumb_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_cls;
    logic [3:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs;
    logic [3:0]  in_rn;
    logic [21:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        err;
    logic [15:0] stat_instr;
    logic [7:0]  stat_err;

    int n_checks = 0;
    int n_errors = 0;

    thumb_encoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cls     (in_cls),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rn      (in_rn),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .err        (err),
        .stat_instr (stat_instr),
        .stat_err   (stat_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cls;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rn;
        logic [21:0] imm;
        logic        exp_err;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [4:0] cls, input logic [3:0] op, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [3:0] rn, input logic [21:0] imm,
                                input logic exp_err, input logic [15:0] exp_instr);
        vec_t v;
        v.cls = cls; v.op = op; v.rd = rd; v.rs = rs; v.rn = rn; v.imm = imm;
        v.exp_err = exp_err; v.exp_instr = exp_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] cls, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [3:0] rn, input logic [21:0] imm);
        in_valid = 1'b1;
        in_cls = cls; in_op = op; in_rd = rd; in_rs = rs; in_rn = rn; in_imm = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ok;
        int n_rej;
        int got;
        int valid_seen;
        logic [15:0] exp_q[5];
        logic acc;
        logic pop;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_cls = '0; in_op = '0; in_rd = '0; in_rs = '0; in_rn = '0; in_imm = '0;

        vecs[0]  = mk(5'd1,  4'h0, 4'd1, 4'd2, 4'd0, 22'h5,     1'b0, 16'h0151);
        vecs[1]  = mk(5'd3,  4'h0, 4'd3, 4'd0, 4'd0, 22'h42,    1'b0, 16'h2342);
        vecs[2]  = mk(5'd16, 4'h0, 4'd0, 4'd0, 4'd0, 22'hFE,    1'b0, 16'hD0FE);
        vecs[3]  = mk(5'd2,  4'h1, 4'd1, 4'd2, 4'd3, 22'h0,     1'b0, 16'h1AD1);
        vecs[4]  = mk(5'd4,  4'hA, 4'd6, 4'd5, 4'd0, 22'h0,     1'b0, 16'h42AE);
        vecs[5]  = mk(5'd6,  4'h2, 4'd9, 4'hC, 4'd0, 22'h0,     1'b0, 16'h46E1);
        vecs[6]  = mk(5'd7,  4'h3, 4'd2, 4'd1, 4'd7, 22'h0,     1'b0, 16'h5DCA);
        vecs[7]  = mk(5'd9,  4'h1, 4'd4, 4'd3, 4'd0, 22'h1F,    1'b0, 16'h6FDC);
        vecs[8]  = mk(5'd11, 4'h1, 4'd5, 4'd0, 4'd0, 22'h80,    1'b0, 16'h9D80);
        vecs[9]  = mk(5'd12, 4'h0, 4'd7, 4'd0, 4'd0, 22'h11,    1'b0, 16'hA711);
        vecs[10] = mk(5'd18, 4'h0, 4'd0, 4'd0, 4'd0, 22'hABC,   1'b0, 16'hE2BC);
        vecs[11] = mk(5'd1,  4'h2, 4'd7, 4'd7, 4'd0, 22'h3F,    1'b0, 16'h17FF);
        vecs[12] = mk(5'd16, 4'hD, 4'd0, 4'd0, 4'd0, 22'h1FF,   1'b0, 16'hDDFF);
        vecs[13] = mk(5'd5,  4'h0, 4'd0, 4'd0, 4'd0, 22'h0,     1'b1, 16'h0000);
        vecs[14] = mk(5'd16, 4'hF, 4'd0, 4'd0, 4'd0, 22'h0,     1'b1, 16'h0000);
        vecs[15] = mk(5'd4,  4'h0, 4'd8, 4'd0, 4'd0, 22'h0,     1'b1, 16'h0000);
        vecs[16] = mk(5'd1,  4'h3, 4'd1, 4'd1, 4'd0, 22'h0,     1'b1, 16'h0000);
        vecs[17] = mk(5'd16, 4'hE, 4'd0, 4'd0, 4'd0, 22'h0,     1'b1, 16'h0000);
        vecs[18] = mk(5'd3,  4'h0, 4'd1, 4'd0, 4'd8, 22'h0,     1'b1, 16'h0000);
        vecs[19] = mk(5'd0,  4'h0, 4'd0, 4'd0, 4'd0, 22'h0,     1'b1, 16'h0000);

        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset stat_instr", 32'(stat_instr), 32'd0);
        chk("reset stat_err", 32'(stat_err), 32'd0);

        n_ok = 0; n_rej = 0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            drive(vecs[i].cls, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rn, vecs[i].imm);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(!vecs[i].exp_err));
            if (vecs[i].exp_err) n_rej++;
            else begin
                n_ok++;
                chk($sformatf("vec%0d out_instr", i), 32'(out_instr), 32'(vecs[i].exp_instr));
            end
            tick();
            chk($sformatf("vec%0d err one cycle", i), 32'(err), 32'd0);
            chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
        end
`ifdef THUMB_ENC_STATS_EN
        chk("stat_instr after table", 32'(stat_instr), 32'(n_ok));
        chk("stat_err after table", 32'(stat_err), 32'(n_rej));
`else
        chk("stat_instr tied off", 32'(stat_instr), 32'd0);
        chk("stat_err tied off", 32'(stat_err), 32'd0);
`endif

        // LONG_BL: two consecutive halfwords, in_ready low during BL2
        drive(5'd20, 4'h0, 4'd0, 4'd0, 4'd0, 22'h000801);
        tick();
        in_valid = 1'b0;
        chk("bl first word valid", 32'(out_valid), 32'd1);
        chk("bl first word", 32'(out_instr), 32'hF001);
        chk("bl2 in_ready low", 32'(in_ready), 32'd0);
        tick();
        chk("bl second word valid", 32'(out_valid), 32'd1);
        chk("bl second word", 32'(out_instr), 32'hF801);
        chk("bl back to idle", 32'(in_ready), 32'd1);
        tick();
        chk("bl drained", 32'(out_valid), 32'd0);

        // Back-pressure: four fill the queue, the fifth waits, then all drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_q[i] = 16'(i + 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill%0d in_ready", i), 32'(in_ready), 32'd1);
            drive(5'd1, 4'h0, 4'(i + 1), 4'd0, 4'd0, 22'h0);
            tick();
        end
        drive(5'd1, 4'h0, 4'd5, 4'd0, 4'd0, 22'h0);
        chk("full in_ready low", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("full still blocked", 32'(in_ready), 32'd0);
        chk("full head held", 32'(out_instr), 32'h0001);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (cyc == 0) chk("pop does not free same cycle", 32'(in_ready), 32'd0);
            if (pop) begin
                chk($sformatf("drain%0d order", got), 32'(out_instr), 32'(exp_q[got]));
                got++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("drain count", 32'(got), 32'd5);
        chk("drain empty", 32'(out_valid), 32'd0);

        // Reset while in BL2 with two halfwords queued
        out_ready = 1'b0;
        drive(5'd1, 4'h0, 4'd1, 4'd0, 4'd0, 22'h0);
        tick();
        drive(5'd20, 4'h0, 4'd0, 4'd0, 4'd0, 22'h000801);
        tick();
        in_valid = 1'b0;
        chk("pre-reset in BL2", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("bl2 reset out_valid", 32'(out_valid), 32'd0);
        chk("bl2 reset in_ready", 32'(in_ready), 32'd1);
        chk("bl2 reset stat_instr", 32'(stat_instr), 32'd0);
        chk("bl2 reset stat_err", 32'(stat_err), 32'd0);
        out_ready = 1'b1;
        valid_seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (out_valid) valid_seen++;
            tick();
        end
        chk("no word after reset", 32'(valid_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/thumb_encoder.md
THUMB_ENCODER -- requirements
Module: thumb_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, output queue depth in halfwords (power of two, >=2).
REQ-002 The block SHALL have ports clk in 1, single clock; rst in 1, reset, synchronous active-high.
REQ-003 The block SHALL have ports in_valid in 1, in_ready out 1, request handshake.
REQ-004 The block SHALL have port in_cls in 5, instruction class code from the shared package.
REQ-005 The block SHALL have ports in_op in 4, in_rd in 4, in_rs in 4, in_rn in 4, in_imm in 22: sub-op/condition, registers, immediate/offset.
REQ-006 The block SHALL have ports out_valid out 1, out_ready in 1, out_instr out 16, encoded halfword stream.
REQ-007 The block SHALL have port err out 1, one-cycle pulse on a rejected request.
REQ-008 The block SHALL have ports stat_instr out 16 and stat_err out 8, statistics counters.

Function
REQ-009 A request SHALL be accepted on a rising clk edge with in_valid and in_ready both high.
REQ-010 in_ready SHALL equal (state==IDLE) && !fifo_full; a pop in the same cycle SHALL NOT free a slot for that cycle's push.
REQ-011 Accepted valid requests SHALL be written to the FIFO on the accept edge; out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-012 Encodings, field truncation silent: SHIFT(1) {000,op[1:0],imm[4:0],rs[2:0],rd[2:0]}; ADD_SUB(2) {00011,op[1:0],rn[2:0],rs[2:0],rd[2:0]}; MOVE_C(3) {001,op[1:0],rd[2:0],imm[7:0]}; ALU(4) {010000,op,rs[2:0],rd[2:0]}; HIREG(6) {010001,op[1:0],rd[3],rs[3],rs[2:0],rd[2:0]}.
REQ-013 Encodings continued: LDSR_REG(7) {0101,op[1:0],0,rn[2:0],rs[2:0],rd[2:0]}; LDSR_IMM(9) {011,op[1:0],imm[4:0],rs[2:0],rd[2:0]}; LDSR_SP(11) {1001,op[0],rd[2:0],imm[7:0]}; LD_A(12) {1010,op[0],rd[2:0],imm[7:0]}; COND_B(16) {1101,op,imm[7:0]}; UNCOND_B(18) {11100,imm[10:0]}.
REQ-014 LONG_BL(20) SHALL emit two halfwords in order: {11110,imm[21:11]} on accept, then {11111,imm[10:0]}.
REQ-015 FSM states IDLE, BL2: IDLE->BL2 on accepting LONG_BL; BL2 holds stored imm[10:0], pushes when !fifo_full, then ->IDLE; in_ready low throughout BL2.
REQ-016 Rejected requests: undefined class code; rd[3]/rs[3]/rn[3] set in any class except HIREG; SHIFT with op[1:0]==11; COND_B with op 1110 or 1111.
REQ-017 A rejected request SHALL be consumed, pulse err high for exactly the cycle after accept, and write nothing to the FIFO.
REQ-018 FIFO SHALL pop on out_valid && out_ready; out_instr SHALL hold head value while out_valid && !out_ready; out_valid low when empty, pop ignored.
REQ-019 Order SHALL be strictly preserved; simultaneous push and pop when non-full/non-empty SHALL keep count unchanged.

Reset
REQ-020 On rst: state IDLE, FIFO emptied, out_valid 0, err 0, stat_instr 0, stat_err 0, in_ready 1 the following cycle.
REQ-021 rst during BL2 SHALL discard the pending second halfword and all queued halfwords.

Configuration
REQ-022 Macro THUMB_ENC_STATS_EN defined: stat_instr counts accepted valid requests (wraps at 16 bits), stat_err counts rejected requests (saturates at 255).
REQ-023 Macro THUMB_ENC_STATS_EN undefined: stat_instr and stat_err ports SHALL remain present and tied to 0; no counter logic.

Structure
REQ-024 Shared package thumb_pkg SHALL hold the 5-bit class codes (SHIFT=1 ... LONG_BL=20, INVALID=0) and format prefix constants, shared with the decode control unit.
REQ-025 The FIFO SHALL be a sub-module enc_fifo (parameter DEPTH, width 16, push/pop/full/empty).

Verification
REQ-026 cls=1 op=0 rd=1 rs=2 imm=5 -> out_instr 0x0151, err 0.
REQ-027 cls=3 op=0 rd=3 imm=0x42 -> 0x2342; cls=16 op=0 imm=0xFE -> 0xD0FE.
REQ-028 cls=20 imm=0x000801, out_ready=1 -> 0xF001 then 0xF801 consecutive; in_ready low for the BL2 cycle.
REQ-029 cls=5; then cls=16 op=0xF; then cls=4 rd=8 -> err pulse each, FIFO stays empty, stat_err=3 with macro, 0 without.
REQ-030 out_ready=0, FIFO_DEPTH=4, five back-to-back SHIFT requests -> in_ready low after fourth, fifth held; out_ready=1 -> five words drain in issue order.
REQ-031 rst asserted in BL2 with two words queued -> next cycle out_valid 0, in_ready 1, no 0xF8xx word ever emitted.
